// File: rtl/uart_receiver.sv
// uart_receiver: 8-bit UART receiver with a 2-flop rx synchronizer and mid-bit sampling.
// Optional even-parity bit between bit 7 and stop, enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy,
  output logic [2:0] o_dbg_state
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             w_load;
  logic             w_ferr;
  logic             w_rx_fall;
  logic             w_cnt_max;
  logic             w_cnt_half;
`ifdef UART_RX_PARITY_EN
  logic             r_par;
  logic             w_par_nxt;
  logic             r_parity_err;
  logic             w_perr;
  logic             w_par_bad;
`endif

  // Synchronizer flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_rx_fall  = r_rx_prev & ~r_rx_sync;
  assign w_cnt_max  = (r_cnt == CNT_MAX);
  assign w_cnt_half = (r_cnt == CNT_HALF);
`ifdef UART_RX_PARITY_EN
  assign w_par_bad  = r_par ^ (^r_shift);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
    w_perr      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_rx_fall) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_cnt_half) begin
          if (r_rx_sync) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_DATA;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_cnt_max) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_sync, r_shift[7:1]};
          w_bit_nxt   = r_bit + 1'b1;
          if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_cnt_max) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = r_rx_sync;
          w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_cnt_max) begin
          w_cnt_nxt = '0;
          if (r_rx_sync) begin
`ifdef UART_RX_PARITY_EN
            w_perr = w_par_bad;
            w_load = ~w_par_bad;
`else
            w_load = 1'b1;
`endif
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      // A held-low line parks here so a break yields a single frame_err.
      S_WAIT_IDLE: begin
        if (r_rx_sync) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // valid, frame_err and parity_err are one-cycle strobes with no backpressure;
  // data is only rewritten together with valid and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= w_load;
      r_frame_err <= w_ferr;
      if (w_load) begin
        r_data <= r_shift;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_perr;
    end
  end
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign data        = r_data;
  assign valid       = r_valid;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver at CLKS_PER_BIT=16.
// Expected output events are queued by the frame driver and popped by the output monitor.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;
  logic [2:0] dbg_state;

  int         n_checks = 0;
  int         n_fail = 0;
  // {kind, data}: kind 0 = valid, 1 = frame_err, 2 = parity_err
  logic [9:0] exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // mode 0: good frame, 1: stop bit 0, 2: wrong parity bit
  task automatic send_frame(input logic [7:0] b, input int mode);
    logic par_bit;
    par_bit = (^b) ^ (mode == 2);
    if (mode == 1) begin
      exp_q.push_back({2'd1, last_good});
    end else if (mode == 2) begin
      exp_q.push_back({2'd2, last_good});
    end else begin
      exp_q.push_back({2'd0, b});
      last_good = b;
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit);
`else
    if (par_bit === 1'bx) rx = 1'b1;
`endif
    send_bit(mode != 1);
  endtask

  // scoreboard: every strobe must match the head of the expected queue
  task automatic monitor_outputs();
    logic [9:0] obs;
    logic [9:0] e;
    int         n_hi;
    forever begin
      @(negedge clk);
      if (valid || frame_err || parity_err) begin
        n_hi = int'(valid) + int'(frame_err) + int'(parity_err);
        n_checks++;
        if (n_hi != 1) begin
          n_fail++;
          $display("FAIL strobe_overlap: valid=%0b frame_err=%0b parity_err=%0b, required at most one high",
                   valid, frame_err, parity_err);
        end
        obs = {(parity_err ? 2'd2 : (frame_err ? 2'd1 : 2'd0)), data};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got kind=%0d data=%h, required no strobe", obs[9:8], obs[7:0]);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_fail++;
            $display("FAIL strobe_match: got kind=%0d data=%h, required kind=%0d data=%h",
                     obs[9:8], obs[7:0], e[9:8], e[7:0]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, required 00", data); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b, required 0", parity_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
    rst_n = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b, required 0", busy); end
  endtask

  task automatic test_single();
    fork
      send_frame(8'hA5, 0);
      begin
        repeat (5 * CPB) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_mid: got %b, required 1", busy); end
      end
    join
    send_bit(1'b1);
    for (int i = 0; i < 20 * CPB && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_missing: %0d pending, required 0", exp_q.size()); end
    exp_q.delete();
    n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h, required a5", data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b, required 0", busy); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 0);
    send_frame(8'hFF, 0);
    send_bit(1'b1);
    for (int i = 0; i < 20 * CPB && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing: %0d pending, required 0", exp_q.size()); end
    exp_q.delete();
    n_checks++; if (data !== 8'hFF) begin n_fail++; $display("FAIL b2b_data: got %h, required ff", data); end
  endtask

  task automatic test_glitch();
    logic [7:0] d0;
    d0 = data;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start_busy: got %b, required 1", busy); end
    @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b, required 0", busy); end
    n_checks++; if (data !== d0) begin n_fail++; $display("FAIL glitch_data: got %h, required %h", data, d0); end
  endtask

  task automatic test_break();
    logic [7:0] d0;
    d0 = last_good;
    send_frame(8'h3C, 1);
    repeat (40 * CPB) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_low: got %b, required 1", busy); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_idle: got %b, required 0", busy); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL break_missing: %0d pending, required 0", exp_q.size()); end
    exp_q.delete();
    n_checks++; if (data !== d0) begin n_fail++; $display("FAIL break_data: got %h, required %h", data, d0); end
    send_bit(1'b1);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    rx = b[3];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b, required 0", busy); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %h, required 00", data); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_good = 8'h00;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h81, 0);
    send_bit(1'b1);
    for (int i = 0; i < 20 * CPB && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL midreset_missing: %0d pending, required 0", exp_q.size()); end
    exp_q.delete();
    n_checks++; if (data !== 8'h81) begin n_fail++; $display("FAIL midreset_data_after: got %h, required 81", data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d0;
    d0 = last_good;
    send_frame(8'h07, 2);
    send_bit(1'b1);
    for (int i = 0; i < 20 * CPB && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL parity_bad_missing: %0d pending, required 0", exp_q.size()); end
    exp_q.delete();
    n_checks++; if (data !== d0) begin n_fail++; $display("FAIL parity_bad_data: got %h, required %h", data, d0); end
    send_frame(8'h07, 0);
    send_bit(1'b1);
    for (int i = 0; i < 20 * CPB && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL parity_good_missing: %0d pending, required 0", exp_q.size()); end
    exp_q.delete();
    n_checks++; if (data !== 8'h07) begin n_fail++; $display("FAIL parity_good_data: got %h, required 07", data); end
  endtask
`endif

  initial begin
    fork
      monitor_outputs();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    repeat (2 * CPB) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
